// File: rtl/sync_fifo_ext_if.sv
// Producer/consumer handshake bundle for sync_fifo_ext.
// master: the side that issues writes/reads; slave: the FIFO itself.
interface sync_fifo_ext_if #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                  w_en;
  logic                  r_en;
  logic                  clr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CntW-1:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, r_en, clr, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, r_en, clr, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_ext #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter bit          FWFT          = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ext_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  full, empty;
  logic                  rd_ok, wr_ok;

  // Status decode and accept rules; clr suppresses both accepts so nothing moves.
  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    empty = (count_q == '0);
    rd_ok = bus.r_en & ~empty & ~bus.clr;
    // A read in the same cycle frees a slot, so a full FIFO still takes the write.
    wr_ok = bus.w_en & (~full | rd_ok) & ~bus.clr;
  end

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (bus.clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PtrW'(1);
      if (rd_ok) rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(wr_ok) - CntW'(rd_ok);
      if (bus.w_en && !wr_ok) ovf_d = 1'b1;
      if (bus.r_en && empty)  udf_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array; contents survive flush and reset, only the pointers move.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q] <= bus.data_in;
  end

  if (FWFT) begin : g_fwft
    // Head word is always presented; stale while empty.
    assign bus.data_out = mem_q[rptr_q];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered read port; holds its value unless a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (bus.clr) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem_q[rptr_q];
      end
    end

    assign bus.data_out = dout_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CntW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CntW'(AEMPTY_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: queue-based reference model, read-data scoreboard,
// directed scenarios, randomized traffic and a separate FWFT instance.
module tb_sync_fifo_ext;
  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_ext_if #(.DEPTH(Depth), .DATA_WIDTH(8)) bus ();
  sync_fifo_ext_if #(.DEPTH(Depth), .DATA_WIDTH(8)) fb ();

  sync_fifo_ext #(
    .DEPTH(Depth), .DATA_WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1'b0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  sync_fifo_ext #(
    .DEPTH(Depth), .DATA_WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1'b1)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fb.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a plain queue, plus flag/data expectations.
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  logic [7:0] m_dout = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count", 32'(bus.count), n);
    chk("full", 32'(bus.full), 32'(n == Depth));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
  endtask

  // One clock of stimulus: verify the previous edge's result, then drive and predict.
  task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit rd, wr;
    @(negedge clk);
    check_state();
    bus.w_en    = w;
    bus.r_en    = r;
    bus.clr     = c;
    bus.data_in = d;
    if (c) begin
      model_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 8'h00;
    end else begin
      rd = r && (model_q.size() > 0);
      wr = w && ((model_q.size() < Depth) || rd);
      if (r && model_q.size() == 0) m_udf = 1'b1;
      if (w && !wr) m_ovf = 1'b1;
      if (rd) begin
        m_dout = model_q.pop_front();
        exp_q.push_back(m_dout);
      end
      if (wr) model_q.push_back(d);
    end
  endtask

  // Scoreboard monitor: whenever the DUT accepts a read, compare the word it presents.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (rst_n && !bus.clr && bus.r_en && !bus.empty) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: got %0h expected none (unexpected read)", bus.data_out);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(bus.data_out), 32'(e));
        end
      end
    end
  end

  task automatic async_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = 8'h00;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.w_en = 1'b0; bus.r_en = 1'b0; bus.clr = 1'b0; bus.data_in = '0;
    fb.w_en  = 1'b0; fb.r_en  = 1'b0; fb.clr  = 1'b0; fb.data_in  = '0;
    #3;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b0, 1'b0, 8'h99);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Streaming with wrap: writes every cycle, reads from the fourth cycle on.
    for (int i = 0; i < 12; i++) step(1'b1, i >= 3, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Simultaneous access at full, then at empty after a flush of the flags.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 1'b0, 8'h00);

    // Flush at count 5 with a concurrent write that must be dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b0, 1'b1, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Async reset between edges at count 3 with overflow set.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    async_reset();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 63) == 0, 8'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // FWFT instance: head word visible without a read, next word after the pop edge.
    @(negedge clk);
    fb.w_en = 1'b1; fb.data_in = 8'h5A;
    @(negedge clk);
    fb.w_en = 1'b0;
    chk("fwft_empty", 32'(fb.empty), 32'd0);
    chk("fwft_first", 32'(fb.data_out), 32'h5A);
    fb.w_en = 1'b1; fb.data_in = 8'h6B;
    @(negedge clk);
    fb.w_en = 1'b0; fb.r_en = 1'b1;
    chk("fwft_head_hold", 32'(fb.data_out), 32'h5A);
    chk("fwft_count2", 32'(fb.count), 32'd2);
    @(negedge clk);
    fb.r_en = 1'b0;
    chk("fwft_next", 32'(fb.data_out), 32'h6B);
    chk("fwft_count1", 32'(fb.count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
